fetch_unit: RTL and testbench

- Instruction-fetch front end that feeds the ctrl FSM. It owns the program counter (PC) and the instruction register (IR), and runs the request/response handshake with instruction memory.
- It supplies OPCODE and MM to ctrl, and returns FETCH_DONE when ctrl requests a fetch.
- It resolves bra/brr/bne against ALU status when ctrl signals the execute step, and latches a halt on hlt.

---
 rtl/fetch_unit.sv | 115 +++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns PC and IR, runs the instruction-memory
// handshake with a response timeout, resolves bra/brr/bne and latches halt.
module fetch_unit #(
    parameter int AW      = 16,
    parameter int TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          fetch_req,
    input  logic          br_en,
    input  logic [3:0]    stat,
    output logic          imem_rd,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [31:0]   imem_data,
    output logic [31:0]   ir,
    output logic [3:0]    opcode,
    output logic [3:0]    mm,
    output logic [AW-1:0] pc,
    output logic          fetch_done,
    output logic          fetch_err,
    output logic          halted
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] WAIT = 2'd1;
    localparam logic [1:0] HALT = 2'd2;

    localparam logic [3:0] OP_BRA = 4'd4;
    localparam logic [3:0] OP_BRR = 4'd5;
    localparam logic [3:0] OP_BNE = 4'd6;
    localparam logic [3:0] OP_HLT = 4'd15;

    logic [1:0]    state;
    logic [AW-1:0] pc_cur;
    logic [7:0]    wait_cnt;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [AW-1:0] br_offset;
    logic [AW-1:0] fetch_pc;

    assign opcode    = ir[31:28];
    assign mm        = ir[27:24];
    assign br_offset = AW'($signed(ir[15:0]));

    // Branch decision for the instruction currently held in IR.
    always_comb begin
        br_taken  = 1'b0;
        br_target = ir[AW-1:0];
        case (opcode)
            OP_BRA: br_taken = 1'b1;
            OP_BRR: begin
                br_taken  = 1'b1;
                br_target = pc_cur + br_offset;
            end
            OP_BNE: br_taken = ((stat & mm) == 4'd0);
            default: br_taken = 1'b0;
        endcase
    end

    // A branch in the same cycle as a fetch request redirects that fetch.
    assign fetch_pc = (br_en && br_taken) ? br_target : pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pc         <= '0;
            pc_cur     <= '0;
            ir         <= '0;
            imem_rd    <= 1'b0;
            imem_addr  <= '0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            halted     <= 1'b0;
            wait_cnt   <= '0;
        end else begin
            imem_rd    <= 1'b0;
            fetch_done <= 1'b0;
            fetch_err  <= 1'b0;
            case (state)
                IDLE: begin
                    pc <= fetch_pc;
                    if (fetch_req) begin
                        imem_rd   <= 1'b1;
                        imem_addr <= fetch_pc;
                        wait_cnt  <= '0;
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_valid) begin
                        ir         <= imem_data;
                        pc_cur     <= imem_addr;
                        pc         <= imem_addr + AW'(1);
                        fetch_done <= 1'b1;
                        if (imem_data[31:28] == OP_HLT) begin
                            halted <= 1'b1;
                            state  <= HALT;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (wait_cnt == 8'(TIMEOUT - 1)) begin
                        fetch_err <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                HALT: state <= HALT;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized
// fetch/branch traffic compared against a PC/IR reference model.
module tb_fetch_unit;

    localparam int TIMEOUT = 15;
    localparam int WINDOW  = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fetch_req = 1'b0;
    logic        br_en = 1'b0;
    logic [3:0]  stat = 4'd0;
    logic        imem_rd;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'd0;
    logic [31:0] ir;
    logic [3:0]  opcode;
    logic [3:0]  mm;
    logic [15:0] pc;
    logic        fetch_done;
    logic        fetch_err;
    logic        halted;

    int total = 0;
    int bad = 0;

    logic [15:0] m_pc;
    logic [15:0] m_pc_cur;
    logic [31:0] m_ir;
    bit          m_halted;

    fetch_unit #(.AW(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .fetch_req(fetch_req), .br_en(br_en), .stat(stat),
        .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_valid(imem_valid),
        .imem_data(imem_data), .ir(ir), .opcode(opcode), .mm(mm), .pc(pc),
        .fetch_done(fetch_done), .fetch_err(fetch_err), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("[TB] FAIL watchdog: got=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Where the program counter goes when ctrl asks for a branch now.
    function automatic logic [15:0] model_branch_target(input logic [3:0] st);
        int t;
        case (int'(m_ir[31:28]))
            4: return m_ir[15:0];
            5: begin
                t = int'(m_pc_cur) + int'($signed(m_ir[15:0]));
                return t[15:0];
            end
            6: return ((st & m_ir[27:24]) == 4'd0) ? m_ir[15:0] : m_pc;
            default: return m_pc;
        endcase
    endfunction

    task automatic predict_fetch(input logic [31:0] data, input int resp, input logic with_br,
                                 input logic [3:0] st, output int exp_rd,
                                 output logic [15:0] exp_addr, output int exp_done,
                                 output int exp_err);
        logic [15:0] target;
        exp_addr = 16'd0;
        exp_done = -1;
        exp_err  = -1;
        exp_rd   = 0;
        if (m_halted) return;
        target   = with_br ? model_branch_target(st) : m_pc;
        m_pc     = target;
        exp_addr = target;
        exp_rd   = 1;
        if (resp >= 1 && resp <= TIMEOUT - 1) begin
            exp_done = resp + 2;
            m_ir     = data;
            m_pc_cur = target;
            m_pc     = target + 16'd1;
            if (data[31:28] == 4'hF) m_halted = 1'b1;
        end else begin
            exp_err = TIMEOUT + 1;
        end
    endtask

    // Issues one fetch request and plays instruction memory; resp<1 = no reply.
    task automatic run_fetch(input logic [31:0] data, input int resp, input logic with_br,
                             input logic [3:0] st, output int rd_cnt,
                             output logic [15:0] rd_addr, output int done_cyc,
                             output int done_cnt, output int err_cyc, output int err_cnt,
                             output int both);
        int rd_cyc;
        rd_cnt = 0; rd_addr = 16'd0; done_cyc = -1; done_cnt = 0;
        err_cyc = -1; err_cnt = 0; both = 0; rd_cyc = -1;
        @(negedge clk);
        fetch_req = 1'b1;
        br_en     = with_br;
        stat      = st;
        for (int c = 1; c <= WINDOW; c++) begin
            @(negedge clk);
            fetch_req = 1'b0;
            br_en     = 1'b0;
            if (imem_rd) begin
                rd_cnt++;
                if (rd_cyc < 0) begin
                    rd_cyc  = c;
                    rd_addr = imem_addr;
                end
            end
            if (fetch_done) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            if (fetch_err) begin
                err_cnt++;
                if (err_cyc < 0) err_cyc = c;
            end
            if (fetch_done && fetch_err) both++;
            if (resp > 0 && rd_cyc > 0 && c == rd_cyc + resp) begin
                imem_valid = 1'b1;
                imem_data  = data;
            end else begin
                imem_valid = 1'b0;
            end
        end
        imem_valid = 1'b0;
    endtask

    task automatic do_branch(input logic [3:0] st);
        @(negedge clk);
        br_en = 1'b1;
        stat  = st;
        @(negedge clk);
        br_en = 1'b0;
        if (!m_halted) m_pc = model_branch_target(st);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pc = 16'd0; m_pc_cur = 16'd0; m_ir = 32'd0; m_halted = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total++; if (pc !== 16'd0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=0000", pc); end
        total++; if (ir !== 32'd0) begin bad++; $display("[TB] FAIL reset_ir got=%h exp=00000000", ir); end
        total++; if (opcode !== 4'd0 || mm !== 4'd0) begin bad++; $display("[TB] FAIL reset_op_mm got=%h/%h exp=0/0", opcode, mm); end
        total++; if (imem_rd !== 1'b0 || imem_addr !== 16'd0) begin bad++; $display("[TB] FAIL reset_imem got=%b/%h exp=0/0000", imem_rd, imem_addr); end
        total++; if (fetch_done !== 1'b0 || fetch_err !== 1'b0 || halted !== 1'b0) begin bad++; $display("[TB] FAIL reset_flags got=%b%b%b exp=000", fetch_done, fetch_err, halted); end
    endtask

    task automatic test_basic_fetch();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr;
        predict_fetch(32'h8A000000, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h8A000000, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_cnt !== 1) begin bad++; $display("[TB] FAIL basic_rd_cycles got=%0d exp=1", rd_cnt); end
        total++; if (rd_addr !== 16'd0) begin bad++; $display("[TB] FAIL basic_rd_addr got=%h exp=0000", rd_addr); end
        total++; if (done_cyc !== 3 || done_cnt !== 1) begin bad++; $display("[TB] FAIL basic_done got=cyc%0d/n%0d exp=cyc3/n1", done_cyc, done_cnt); end
        total++; if (err_cnt !== 0) begin bad++; $display("[TB] FAIL basic_err got=%0d exp=0", err_cnt); end
        total++; if (opcode !== 4'h8 || mm !== 4'hA) begin bad++; $display("[TB] FAIL basic_op_mm got=%h/%h exp=8/a", opcode, mm); end
        total++; if (pc !== 16'd1) begin bad++; $display("[TB] FAIL basic_pc got=%h exp=0001", pc); end
    endtask

    task automatic test_brr();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr;
        predict_fetch(32'h40000010, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h40000010, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        do_branch(4'd0);
        total++; if (pc !== 16'h0010) begin bad++; $display("[TB] FAIL bra_pc got=%h exp=0010", pc); end
        predict_fetch(32'h5000FFFE, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h5000FFFE, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_addr !== 16'h0010) begin bad++; $display("[TB] FAIL brr_fetch_addr got=%h exp=0010", rd_addr); end
        do_branch(4'd0);
        total++; if (pc !== 16'h000E) begin bad++; $display("[TB] FAIL brr_pc got=%h exp=000e", pc); end
        predict_fetch(32'h00000000, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h00000000, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_addr !== 16'h000E) begin bad++; $display("[TB] FAIL brr_next_addr got=%h exp=000e", rd_addr); end
        total++; if (pc !== 16'h000F) begin bad++; $display("[TB] FAIL brr_next_pc got=%h exp=000f", pc); end
    endtask

    task automatic test_bne();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr;
        predict_fetch(32'h64000020, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h64000020, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        do_branch(4'h0);
        total++; if (pc !== 16'h0020) begin bad++; $display("[TB] FAIL bne_taken_pc got=%h exp=0020", pc); end
        predict_fetch(32'h64000020, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h64000020, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        do_branch(4'h4);
        total++; if (pc !== 16'h0021) begin bad++; $display("[TB] FAIL bne_not_taken_pc got=%h exp=0021", pc); end
        // Branch and fetch together: the fetch must go to the taken target.
        predict_fetch(32'h01000000, 1, 1'b1, 4'h0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h01000000, 1, 1'b1, 4'h0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_addr !== 16'h0020) begin bad++; $display("[TB] FAIL br_fetch_addr got=%h exp=0020", rd_addr); end
        total++; if (pc !== 16'h0021) begin bad++; $display("[TB] FAIL br_fetch_pc got=%h exp=0021", pc); end
    endtask

    task automatic test_timeout();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr, pc_before;
        logic [31:0] ir_before;
        pc_before = m_pc;
        ir_before = m_ir;
        predict_fetch(32'h11111111, -1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h11111111, -1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (err_cnt !== 1 || err_cyc !== TIMEOUT + 1) begin bad++; $display("[TB] FAIL timeout_err got=n%0d/cyc%0d exp=n1/cyc%0d", err_cnt, err_cyc, TIMEOUT + 1); end
        total++; if (done_cnt !== 0) begin bad++; $display("[TB] FAIL timeout_done got=%0d exp=0", done_cnt); end
        total++; if (pc !== pc_before || ir !== ir_before) begin bad++; $display("[TB] FAIL timeout_state got=%h/%h exp=%h/%h", pc, ir, pc_before, ir_before); end
        // Response on the last allowed wait cycle still succeeds.
        predict_fetch(32'h22220000, TIMEOUT - 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h22220000, TIMEOUT - 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (done_cyc !== TIMEOUT + 1 || err_cnt !== 0) begin bad++; $display("[TB] FAIL timeout_edge got=cyc%0d/err%0d exp=cyc%0d/err0", done_cyc, err_cnt, TIMEOUT + 1); end
        total++; if (ir !== 32'h22220000) begin bad++; $display("[TB] FAIL timeout_edge_ir got=%h exp=22220000", ir); end
        predict_fetch(32'h33330000, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h33330000, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (done_cyc !== 3 || ir !== 32'h33330000 || pc !== m_pc) begin bad++; $display("[TB] FAIL after_timeout got=cyc%0d/%h/%h exp=cyc3/33330000/%h", done_cyc, ir, pc, m_pc); end
    endtask

    task automatic test_halt();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr, pc_before;
        predict_fetch(32'hF0000000, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'hF0000000, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (done_cnt !== 1 || halted !== 1'b1) begin bad++; $display("[TB] FAIL hlt_fetch got=n%0d/h%b exp=n1/h1", done_cnt, halted); end
        pc_before = pc;
        run_fetch(32'h12345678, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_cnt !== 0 || done_cnt !== 0) begin bad++; $display("[TB] FAIL halt_ignores_req got=rd%0d/done%0d exp=rd0/done0", rd_cnt, done_cnt); end
        total++; if (ir !== 32'hF0000000 || halted !== 1'b1 || pc !== pc_before) begin bad++; $display("[TB] FAIL halt_sticky got=%h/%b/%h exp=f0000000/1/%h", ir, halted, pc, pc_before); end
        do_reset();
        total++; if (halted !== 1'b0 || pc !== 16'd0 || opcode !== 4'd0) begin bad++; $display("[TB] FAIL halt_reset got=%b/%h/%h exp=0/0000/0", halted, pc, opcode); end
    endtask

    task automatic test_wrap_and_reset_mid_fetch();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err;
        logic [15:0] rd_addr, e_addr;
        int seen_done;
        predict_fetch(32'h4000FFFF, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h4000FFFF, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        do_branch(4'd0);
        predict_fetch(32'h01234567, 1, 1'b0, 4'd0, e_rd, e_addr, e_done, e_err);
        run_fetch(32'h01234567, 1, 1'b0, 4'd0, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
        total++; if (rd_addr !== 16'hFFFF || pc !== 16'h0000) begin bad++; $display("[TB] FAIL wrap got=%h/%h exp=ffff/0000", rd_addr, pc); end
        do_reset();
        @(negedge clk);
        fetch_req = 1'b1;
        @(negedge clk);
        fetch_req = 1'b0;
        total++; if (imem_rd !== 1'b1) begin bad++; $display("[TB] FAIL midreset_rd got=%b exp=1", imem_rd); end
        rst = 1'b1;
        @(negedge clk);
        rst        = 1'b0;
        imem_valid = 1'b1;
        imem_data  = 32'h8A000000;
        seen_done  = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            imem_valid = 1'b0;
            if (fetch_done) seen_done++;
        end
        total++; if (ir !== 32'd0 || seen_done !== 0) begin bad++; $display("[TB] FAIL midreset_ignored got=%h/done%0d exp=00000000/done0", ir, seen_done); end
        m_pc = 16'd0; m_pc_cur = 16'd0; m_ir = 32'd0; m_halted = 1'b0;
    endtask

    task automatic test_random();
        int rd_cnt, done_cyc, done_cnt, err_cyc, err_cnt, both, e_rd, e_done, e_err, resp;
        logic [15:0] rd_addr, e_addr;
        logic [31:0] data;
        logic [3:0]  op, st;
        logic        with_br;
        for (int i = 0; i < 120; i++) begin
            if (m_halted) do_reset();
            st = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) begin
                do_branch(st);
                total++; if (pc !== m_pc) begin bad++; $display("[TB] FAIL rnd_branch_pc got=%h exp=%h", pc, m_pc); end
            end else begin
                data = $urandom;
                op   = 4'($urandom_range(0, 15));
                if (op == 4'hF && $urandom_range(0, 3) != 0) op = 4'($urandom_range(4, 6));
                data[31:28] = op;
                resp    = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(1, TIMEOUT + 1));
                with_br = ($urandom_range(0, 3) == 0);
                predict_fetch(data, resp, with_br, st, e_rd, e_addr, e_done, e_err);
                run_fetch(data, resp, with_br, st, rd_cnt, rd_addr, done_cyc, done_cnt, err_cyc, err_cnt, both);
                total++; if (rd_cnt !== e_rd || (e_rd == 1 && rd_addr !== e_addr)) begin bad++; $display("[TB] FAIL rnd_rd got=n%0d/%h exp=n%0d/%h", rd_cnt, rd_addr, e_rd, e_addr); end
                total++; if (done_cyc !== e_done || err_cyc !== e_err || both !== 0) begin bad++; $display("[TB] FAIL rnd_timing got=d%0d/e%0d/b%0d exp=d%0d/e%0d/b0", done_cyc, err_cyc, both, e_done, e_err); end
                total++; if (pc !== m_pc || ir !== m_ir || halted !== m_halted) begin bad++; $display("[TB] FAIL rnd_state got=%h/%h/%b exp=%h/%h/%b", pc, ir, halted, m_pc, m_ir, m_halted); end
            end
        end
    endtask

    initial begin
        m_pc = 16'd0; m_pc_cur = 16'd0; m_ir = 32'd0; m_halted = 1'b0;
        $display("[TB] starting fetch_unit bench");
        test_reset();
        test_basic_fetch();
        test_brr();
        test_bne();
        test_timeout();
        test_halt();
        test_wrap_and_reset_mid_fetch();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
